// File: rtl/spi_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spi_rx_frame_ctrl
//
// Assembles the bit stream from the SPI receive PHY (already in the system
// clock domain) into bytes. It then decodes each frame as a register access:
//   byte 0      : header {rw, addr[6:0]}
//   byte 1..N   : rw=1 -> each byte is written to the register bank
//                 rw=0 -> dummy bytes that pace read prefetch
//
// Ports
//   clock, rst_n        system clock, asynchronous active-low reset
//   start, finish       frame open/close pulses (CS falling / rising)
//   rx_data, rx_valid   received bit and its one-cycle strobe
//   wr_en/addr/data     register write strobe and payload (held between strobes)
//   rd_req/rd_addr      read prefetch strobe and address (held between strobes)
//   busy                high from the cycle after start until the cycle after finish
//   byte_cnt            completed bytes in this frame incl. header, saturating
//   frame_err           one-cycle pulse when a frame closes or restarts mid-byte
// -----------------------------------------------------------------------------
module spi_rx_frame_ctrl #(
  parameter int ADDR_WIDTH = 7,    // header is {rw, addr}, so this must stay 7
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic [7:0]            byte_cnt,
  output logic                  frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA_WR,
    ST_DATA_RD
  } state_e;

  state_e                state_q,     state_d;
  logic [2:0]            bit_cnt_q,   bit_cnt_d;
  logic [7:0]            shift_q,     shift_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic                  wr_en_q,     wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
  logic [7:0]            wr_data_q,   wr_data_d;
  logic                  rd_req_q,    rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
  logic                  busy_q,      busy_d;
  logic [7:0]            byte_cnt_q,  byte_cnt_d;
  logic                  frame_err_q, frame_err_d;

  logic [7:0]            shift_nxt;
  logic [2:0]            bit_cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_step;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    byte_cnt_d  = byte_cnt_q;
    frame_err_d = 1'b0;

    // Byte value as it would look with the current bit included
    shift_nxt   = MSB_FIRST ? {shift_q[6:0], rx_data} : {rx_data, shift_q[7:1]};
    bit_cnt_nxt = rx_valid ? bit_cnt_q + 3'd1 : bit_cnt_q;
    addr_step   = AUTO_INC ? addr_q + ADDR_WIDTH'(1) : addr_q;

    if (start) begin
      // Restart has priority over everything, including a coincident bit
      state_d     = ST_HEADER;
      bit_cnt_d   = 3'd0;
      shift_d     = 8'd0;
      byte_cnt_d  = 8'd0;
      busy_d      = 1'b1;
      frame_err_d = (state_q != ST_IDLE) && (bit_cnt_q != 3'd0);
    end else if (state_q != ST_IDLE) begin
      if (rx_valid) begin
        bit_cnt_d = bit_cnt_nxt;
        shift_d   = shift_nxt;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
          case (state_q)
            ST_HEADER: begin
              addr_d = shift_nxt[ADDR_WIDTH-1:0];
              if (shift_nxt[7]) begin
                state_d = ST_DATA_WR;
              end else begin
                state_d   = ST_DATA_RD;
                rd_req_d  = 1'b1;
                rd_addr_d = shift_nxt[ADDR_WIDTH-1:0];
              end
            end
            ST_DATA_WR: begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = shift_nxt;
              addr_d    = addr_step;
            end
            ST_DATA_RD: begin
              // Prefetch the address of the next byte the master will clock out
              addr_d    = addr_step;
              rd_req_d  = 1'b1;
              rd_addr_d = addr_step;
            end
            default: ;
          endcase
        end
      end
      // A bit arriving with finish is consumed first, so it may still complete
      // a byte; only a leftover partial byte is an error.
      if (finish) begin
        state_d     = ST_IDLE;
        bit_cnt_d   = 3'd0;
        shift_d     = 8'd0;
        busy_d      = 1'b0;
        frame_err_d = (bit_cnt_nxt != 3'd0);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      byte_cnt_q  <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign byte_cnt  = byte_cnt_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_frame_ctrl
//
// Two instances share the clock and reset: u_dut0 uses the default
// configuration (MSB first, auto-increment) and u_dut1 uses LSB first with a
// fixed address. A frame-level reference model turns the driven bit stream
// into an ordered list of expected strobes (write, read prefetch, frame error)
// stamped with the cycle they must appear in. A negedge monitor matches every
// observed strobe against that list.
// -----------------------------------------------------------------------------
module tb_spi_rx_frame_ctrl;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]      start_s    = '0;
  logic [1:0]      finish_s   = '0;
  logic [1:0]      rx_data_s  = '0;
  logic [1:0]      rx_valid_s = '0;
  logic [1:0]      wr_en_s, rd_req_s, busy_s, frame_err_s;
  logic [1:0][6:0] wr_addr_s, rd_addr_s;
  logic [1:0][7:0] wr_data_s, byte_cnt_s;

  spi_rx_frame_ctrl u_dut0 (
    .clock(clock), .rst_n(rst_n), .start(start_s[0]), .finish(finish_s[0]),
    .rx_data(rx_data_s[0]), .rx_valid(rx_valid_s[0]),
    .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]), .wr_data(wr_data_s[0]),
    .rd_req(rd_req_s[0]), .rd_addr(rd_addr_s[0]), .busy(busy_s[0]),
    .byte_cnt(byte_cnt_s[0]), .frame_err(frame_err_s[0])
  );

  spi_rx_frame_ctrl #(.MSB_FIRST(1'b0), .AUTO_INC(1'b0)) u_dut1 (
    .clock(clock), .rst_n(rst_n), .start(start_s[1]), .finish(finish_s[1]),
    .rx_data(rx_data_s[1]), .rx_valid(rx_valid_s[1]),
    .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]), .wr_data(wr_data_s[1]),
    .rd_req(rd_req_s[1]), .rd_addr(rd_addr_s[1]), .busy(busy_s[1]),
    .byte_cnt(byte_cnt_s[1]), .frame_err(frame_err_s[1])
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int EV_WR = 1, EV_RD = 2, EV_ERR = 3;
  typedef struct {int kind; int d; int c; int a; int v;} ev_t;
  ev_t exp_q[$];

  int m_active[2], m_hdr_done[2], m_rw[2], m_addr[2], m_nb[2], m_acc[2], m_bc[2];

  function automatic logic [63:0] pack(input int kind, input int d, input int c,
                                       input int a, input int v);
    return {kind[7:0], d[7:0], c[31:0], a[7:0], v[7:0]};
  endfunction

  task automatic expect_ev(input int kind, input int d, input int c, input int a, input int v);
    ev_t e;
    e.kind = kind; e.d = d; e.c = c; e.a = a; e.v = v;
    exp_q.push_back(e);
  endtask

  // Bits presented during cycle c produce strobes visible in cycle c+1.
  task automatic model_cycle(input int d, input bit st, input bit fin, input bit v, input bit b);
    int c, byt;
    bit msb, inc;
    c   = cyc + 1;
    msb = (d == 0);
    inc = (d == 0);
    if (st) begin
      if (m_active[d] != 0 && m_nb[d] != 0) expect_ev(EV_ERR, d, c, 0, 0);
      m_active[d] = 1; m_hdr_done[d] = 0; m_nb[d] = 0; m_acc[d] = 0; m_bc[d] = 0;
      return;
    end
    if (m_active[d] == 0) return;
    if (v) begin
      if (msb) m_acc[d] = (m_acc[d] * 2 + int'(b)) % 256;
      else     m_acc[d] = m_acc[d] + (int'(b) << m_nb[d]);
      m_nb[d]++;
      if (m_nb[d] == 8) begin
        byt = m_acc[d]; m_nb[d] = 0; m_acc[d] = 0;
        if (m_bc[d] < 255) m_bc[d]++;
        if (m_hdr_done[d] == 0) begin
          m_hdr_done[d] = 1;
          m_rw[d]   = byt / 128;
          m_addr[d] = byt % 128;
          if (m_rw[d] == 0) expect_ev(EV_RD, d, c, m_addr[d], 0);
        end else if (m_rw[d] == 1) begin
          expect_ev(EV_WR, d, c, m_addr[d], byt);
          if (inc) m_addr[d] = (m_addr[d] + 1) % 128;
        end else begin
          if (inc) m_addr[d] = (m_addr[d] + 1) % 128;
          expect_ev(EV_RD, d, c, m_addr[d], 0);
        end
      end
    end
    if (fin) begin
      if (m_nb[d] != 0) expect_ev(EV_ERR, d, c, 0, 0);
      m_active[d] = 0; m_nb[d] = 0; m_acc[d] = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 0; m_hdr_done[d] = 0; m_nb[d] = 0; m_acc[d] = 0; m_bc[d] = 0;
    end
    exp_q.delete();
  endtask

  // ---------------- monitor ----------------
  task automatic observe(input logic [63:0] obs);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_strobe", obs, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("strobe", obs, pack(e.kind, e.d, e.c, e.a, e.v));
    end
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        check("missed_strobe", 64'd0, pack(exp_q[0].kind, exp_q[0].d, exp_q[0].c,
                                           exp_q[0].a, exp_q[0].v));
        void'(exp_q.pop_front());
      end
      for (int d = 0; d < 2; d++) begin
        if (wr_en_s[d])     observe(pack(EV_WR, d, cyc, int'(wr_addr_s[d]), int'(wr_data_s[d])));
        if (rd_req_s[d])    observe(pack(EV_RD, d, cyc, int'(rd_addr_s[d]), 0));
        if (frame_err_s[d]) observe(pack(EV_ERR, d, cyc, 0, 0));
      end
    end
  end

  // ---------------- stimulus ----------------
  bit gaps = 1'b1;
  logic [7:0] payload[$];

  task automatic step(input int d, input bit st, input bit fin, input bit v, input bit b);
    start_s[d] = st; finish_s[d] = fin; rx_valid_s[d] = v; rx_data_s[d] = b;
    model_cycle(d, st, fin, v, b);
    @(posedge clock); #1;
    start_s[d] = 1'b0; finish_s[d] = 1'b0; rx_valid_s[d] = 1'b0; rx_data_s[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input int d, input logic [7:0] v, input int nbits, input bit fin_last);
    int idx;
    for (int k = 0; k < nbits; k++) begin
      if (gaps) idle(d, $urandom_range(0, 1));
      idx = (d == 0) ? 7 - k : k;
      step(d, 1'b0, fin_last && (k == nbits - 1), 1'b1, v[idx]);
    end
  endtask

  task automatic frame(input int d, input logic [7:0] hdr, input int nb, input int part,
                       input bit coin, input bit sbit);
    bit hdr_last;
    hdr_last = coin && nb == 0 && part == 0;
    step(d, 1'b1, 1'b0, sbit, 1'($urandom));
    check("busy_after_start", 64'(busy_s[d]), 64'd1);
    check("byte_cnt_after_start", 64'(byte_cnt_s[d]), 64'd0);
    send_byte(d, hdr, 8, hdr_last);
    if (!hdr_last) check("byte_cnt_hdr", 64'(byte_cnt_s[d]), 64'd1);
    for (int i = 0; i < nb; i++) send_byte(d, payload[i], 8, coin && part == 0 && i == nb - 1);
    if (part > 0) send_byte(d, 8'($urandom), part, 1'b0);
    if (!coin || part > 0) step(d, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(d, 2);
    check("busy_after_finish", 64'(busy_s[d]), 64'd0);
    check("byte_cnt_final", 64'(byte_cnt_s[d]), 64'(m_bc[d]));
  endtask

  function automatic logic [63:0] outs(input int d);
    return 64'({wr_en_s[d], rd_req_s[d], busy_s[d], frame_err_s[d], byte_cnt_s[d],
                wr_addr_s[d], wr_data_s[d], rd_addr_s[d]});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs_d0", outs(0), 64'd0);
    check("reset_outs_d1", outs(1), 64'd0);
    rst_n = 1'b1;
    idle(0, 2);

    // Write frame: writes 0x05<-A5, 0x06<-3C
    payload = '{8'hA5, 8'h3C};
    frame(0, 8'h85, 2, 0, 1'b0, 1'b0);
    check("tp1_byte_cnt", 64'(byte_cnt_s[0]), 64'd3);

    // Read frame: prefetch 0x10, 0x11, 0x12
    payload = '{8'($urandom), 8'($urandom)};
    frame(0, 8'h10, 2, 0, 1'b0, 1'b0);

    // Address wrap: 0x7F, 0x00, 0x01
    payload = '{8'($urandom), 8'($urandom), 8'($urandom)};
    frame(0, 8'hFF, 3, 0, 1'b0, 1'b0);

    // Partial trailing byte
    payload = '{8'h11};
    frame(0, 8'h82, 1, 5, 1'b0, 1'b0);

    // Restart mid-byte of a write frame, then a clean frame to 0x03
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(0, 8'h82, 8, 1'b0);
    send_byte(0, 8'h55, 3, 1'b0);
    payload = '{8'($urandom)};
    frame(0, 8'h83, 1, 0, 1'b0, 1'b0);

    // 8th bit of a data byte coincident with finish
    payload = '{8'h6E};
    frame(0, 8'h81, 1, 0, 1'b1, 1'b0);

    // Header-only frames (read header strobes, write header does not)
    payload.delete();
    frame(0, 8'h05, 0, 0, 1'b0, 1'b0);
    frame(0, 8'h9A, 0, 0, 1'b1, 1'b0);

    // Frame closing inside the header
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(0, 8'hC0, 4, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 2);
    check("hdr_partial_busy", 64'(busy_s[0]), 64'd0);

    // finish while idle is ignored
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 2);
    check("idle_finish_busy", 64'(busy_s[0]), 64'd0);

    // start coincident with a bit: the bit is dropped
    payload = '{8'hC3};
    frame(0, 8'h90, 1, 0, 1'b0, 1'b1);

    // LSB-first, fixed address: both writes to 0x04
    payload = '{8'h01, 8'h02};
    frame(1, 8'h84, 2, 0, 1'b0, 1'b0);

    // byte_cnt saturation
    gaps = 1'b0;
    payload.delete();
    for (int i = 0; i < 260; i++) payload.push_back(8'($urandom));
    frame(0, 8'h00, 260, 0, 1'b0, 1'b0);
    check("byte_cnt_sat", 64'(byte_cnt_s[0]), 64'd255);
    gaps = 1'b1;

    // Randomized frames on both configurations
    for (int n = 0; n < 24; n++) begin
      int d, nb, part;
      d    = $urandom_range(0, 1);
      nb   = $urandom_range(0, 4);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      payload.delete();
      for (int i = 0; i < nb; i++) payload.push_back(8'($urandom));
      frame(d, 8'($urandom), nb, part, 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Reset while the completing bit of a write byte is presented
    step(1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(1, 8'h85, 8, 1'b0);
    send_byte(1, 8'h5A, 7, 1'b0);
    rx_valid_s[1] = 1'b1;
    rx_data_s[1]  = 1'b0;
    model_cycle(1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_outs_d1", outs(1), 64'd0);
    check("midreset_outs_d0", outs(0), 64'd0);
    @(posedge clock); #1;
    rx_valid_s[1] = 1'b0;
    @(posedge clock); #1;
    check("midreset_hold_d1", outs(1), 64'd0);
    rst_n = 1'b1;
    idle(1, 3);
    check("post_reset_busy", 64'(busy_s[1]), 64'd0);
    check("post_reset_byte_cnt", 64'(byte_cnt_s[1]), 64'd0);

    idle(0, 3);
    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
